// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD responder.
// Holds the instruction prefix masks and opcodes, DDRAM geometry, the line
// boundary addresses, the controller state enum, and helpers for mapping the
// address counter to a physical DDRAM index and for stepping it with wrap.
package lcd_pkg;

  localparam logic [7:0] SPACE       = 8'h20;
  localparam int         DDRAM_DEPTH = 80;
  localparam logic [6:0] DDRAM_LIMIT = 7'd80;
  localparam logic [6:0] LAST_IDX    = 7'd79;

  // Address-counter line boundaries
  localparam logic [6:0] LINE1_END       = 7'h27;
  localparam logic [6:0] LINE2_START     = 7'h40;
  localparam logic [6:0] LINE2_END       = 7'h67;
  localparam logic [6:0] ONE_LINE_END    = 7'h4F;
  localparam logic [6:0] LINE2_PHYS_BASE = 7'd40;

  // Instruction decode: (data & mask) == op, tested from the highest bit down
  localparam logic [7:0] MSK_SET_DDRAM = 8'h80, OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] MSK_SET_CGRAM = 8'hC0, OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] MSK_FUNC_SET  = 8'hE0, OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] MSK_SHIFT     = 8'hF0, OP_SHIFT     = 8'h10;
  localparam logic [7:0] MSK_DISP_CTRL = 8'hF8, OP_DISP_CTRL = 8'h08;
  localparam logic [7:0] MSK_ENTRY     = 8'hFC, OP_ENTRY     = 8'h04;
  localparam logic [7:0] MSK_HOME      = 8'hFE, OP_HOME      = 8'h02;
  localparam logic [7:0] MSK_CLEAR     = 8'hFF, OP_CLEAR     = 8'h01;

  typedef enum logic [2:0] {
    ST_INIT_FILL,
    ST_IDLE,
    ST_CLR_FILL,
    ST_CLR_WAIT,
    ST_CMD_WAIT
  } lcd_state_e;

  function automatic logic op_match(input logic [7:0] d, input logic [7:0] msk,
                                    input logic [7:0] op);
    return (d & msk) == op;
  endfunction

  // Physical DDRAM index for an address counter value; may exceed 79 for
  // addresses outside the valid ranges, which the RAM treats as unmapped.
  function automatic logic [6:0] phys(input logic [6:0] ac, input logic two_ln);
    logic [6:0] r;
    if (two_ln) begin
      if (ac[6]) r = LINE2_PHYS_BASE + {1'b0, ac[5:0]};
      else       r = {1'b0, ac[5:0]};
    end else begin
      r = ac;
    end
    return r;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc,
                                         input logic two_ln);
    logic [6:0] r;
    if (inc) begin
      if (two_ln && ac == LINE1_END)         r = LINE2_START;
      else if (two_ln && ac == LINE2_END)    r = '0;
      else if (!two_ln && ac == ONE_LINE_END) r = '0;
      else                                   r = ac + 7'd1;
    end else begin
      if (ac == '0)                          r = two_ln ? LINE2_END : ONE_LINE_END;
      else if (two_ln && ac == LINE2_START)  r = LINE1_END;
      else                                   r = ac - 7'd1;
    end
    return r;
  endfunction

  function automatic logic addr_valid(input logic [6:0] a, input logic two_ln);
    logic r;
    if (two_ln) r = (a <= LINE1_END) || ((a >= LINE2_START) && (a <= LINE2_END));
    else        r = (a <= ONE_LINE_END);
    return r;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display data RAM.
// Ports: clk/rst_n; one synchronous write port (we, waddr, wdata); one
// asynchronous read port (raddr -> rdata) for bus reads; one registered
// inspection port (char_addr -> char_out, 1-cycle latency, reset to 0).
// Indices >= 80 are unmapped: writes are dropped and reads return 0.
// The RAM array itself is never reset.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr,
  output logic [7:0] rdata,
  input  logic [6:0] char_addr,
  output logic [7:0] char_out
);

  logic [7:0] mem [DDRAM_DEPTH];
  logic [7:0] char_q, char_d;

  always_ff @(posedge clk) begin
    if (we && (waddr < DDRAM_LIMIT)) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata  = (raddr < DDRAM_LIMIT) ? mem[raddr] : 8'h00;
    char_d = (char_addr < DDRAM_LIMIT) ? mem[char_addr] : 8'h00;
  end

  // Read-before-write: a location written this cycle shows its old value here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) char_q <= 8'h00;
    else        char_q <= char_d;
  end

  assign char_out = char_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Controller-side model of an HD44780 character LCD bus.
// Ports: clk, rst (async active-low); bus inputs LCD_E/LCD_RS/LCD_RW/LCD_DATA;
// bus read outputs LCD_DOUT/LCD_DOE; status outputs busy, addr_ctr, disp_on,
// cursor_on, blink_on, two_line, viol (1-cycle pulse); inspection port
// char_addr -> char_out (registered).
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_INIT_FILL | after reset: write 0x20 to all 80 locations, one per cycle
// ST_IDLE      | not busy, accepting instructions and data
// ST_CLR_FILL  | Clear Display: 80-cycle 0x20 fill, then AC=0 and ID=1
// ST_CLR_WAIT  | remainder of the Clear Display busy time
// ST_CMD_WAIT  | busy time of any other accepted access
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int CLEAR_CYCLES = 1640,
  parameter int CMD_CYCLES   = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  output logic [7:0] LCD_DOUT,
  output logic       LCD_DOE,
  output logic       busy,
  output logic [6:0] addr_ctr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       viol,
  input  logic [6:0] char_addr,
  output logic [7:0] char_out
);

  localparam int MAX_CYC = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYCLES - 1);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       fill_idx_q, fill_idx_d;

  logic       e_s1_q, e_s1_d, e_s2_q, e_s2_d, e_prev_q, e_prev_d;
  logic       cap_rs_q, cap_rs_d, cap_rw_q, cap_rw_d;
  logic [7:0] cap_data_q, cap_data_d;

  logic [6:0] ac_q, ac_d;
  logic       id_q, id_d, shift_q, shift_d;
  logic       dl_q, dl_d, font_q, font_d;
  logic       two_line_q, two_line_d;
  logic       disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
  logic       cg_mode_q, cg_mode_d;
  logic       viol_q, viol_d;

  logic       e_fall, is_idle, go_cmd;
  logic [6:0] phys_ac;
  logic       ram_we;
  logic [6:0] ram_waddr;
  logic [7:0] ram_wdata, ram_rdata;

  // DL, F and S are held for completeness but do not affect behaviour.
  logic       unused_cfg;
  assign unused_cfg = ^{dl_q, font_q, shift_q};

  assign e_fall  = e_prev_q & ~e_s2_q;
  assign is_idle = (state_q == ST_IDLE);
  assign phys_ac = phys(ac_q, two_line_q);

  always_comb begin
    e_s1_d     = LCD_E;
    e_s2_d     = e_s1_q;
    e_prev_d   = e_s2_q;
    cap_rs_d   = cap_rs_q;
    cap_rw_d   = cap_rw_q;
    cap_data_d = cap_data_q;
    // Bus fields track the pins while E is high; the last values seen before
    // the falling edge form the transaction.
    if (e_s2_q) begin
      cap_rs_d   = LCD_RS;
      cap_rw_d   = LCD_RW;
      cap_data_d = LCD_DATA;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_idx_d = fill_idx_q;
    ac_d       = ac_q;
    id_d       = id_q;
    shift_d    = shift_q;
    dl_d       = dl_q;
    font_d     = font_q;
    two_line_d = two_line_q;
    disp_d     = disp_q;
    cursor_d   = cursor_q;
    blink_d    = blink_q;
    cg_mode_d  = cg_mode_q;
    viol_d     = 1'b0;
    go_cmd     = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = phys_ac;
    ram_wdata  = cap_data_q;

    case (state_q)
      ST_INIT_FILL, ST_CLR_FILL: begin
        ram_we     = 1'b1;
        ram_waddr  = fill_idx_q;
        ram_wdata  = SPACE;
        fill_idx_d = fill_idx_q + 7'd1;
        if (state_q == ST_CLR_FILL) cnt_d = cnt_q - CNT_W'(1);
        if (fill_idx_q == LAST_IDX) begin
          fill_idx_d = '0;
          if (state_q == ST_INIT_FILL) begin
            state_d = ST_IDLE;
          end else begin
            ac_d = '0;
            id_d = 1'b1;
            // CLEAR_CYCLES == 80 leaves no wait phase after the fill.
            if (cnt_q == '0) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = ST_CLR_WAIT;
            end
          end
        end
      end
      ST_CLR_WAIT, ST_CMD_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase

    if (e_fall) begin
      if (cap_rw_q) begin
        // Status reads have no side effects; data reads step AC when idle.
        if (cap_rs_q) begin
          if (is_idle) begin
            ac_d   = ac_step(ac_q, id_q, two_line_q);
            go_cmd = 1'b1;
          end else begin
            viol_d = 1'b1;
          end
        end
      end else if (!is_idle) begin
        viol_d = 1'b1;
      end else if (cap_rs_q) begin
        // Data written while in CG mode is accepted but not stored.
        if (!cg_mode_q) begin
          ram_we = 1'b1;
          ac_d   = ac_step(ac_q, id_q, two_line_q);
        end
        go_cmd = 1'b1;
      end else if (op_match(cap_data_q, MSK_SET_DDRAM, OP_SET_DDRAM)) begin
        cg_mode_d = 1'b0;
        if (addr_valid(cap_data_q[6:0], two_line_q)) begin
          ac_d = cap_data_q[6:0];
        end else begin
          ac_d   = '0;
          viol_d = 1'b1;
        end
        go_cmd = 1'b1;
      end else if (op_match(cap_data_q, MSK_SET_CGRAM, OP_SET_CGRAM)) begin
        cg_mode_d = 1'b1;
        go_cmd    = 1'b1;
      end else if (op_match(cap_data_q, MSK_FUNC_SET, OP_FUNC_SET)) begin
        dl_d       = cap_data_q[4];
        two_line_d = cap_data_q[3];
        font_d     = cap_data_q[2];
        go_cmd     = 1'b1;
      end else if (op_match(cap_data_q, MSK_SHIFT, OP_SHIFT)) begin
        if (!cap_data_q[3]) ac_d = ac_step(ac_q, cap_data_q[2], two_line_q);
        go_cmd = 1'b1;
      end else if (op_match(cap_data_q, MSK_DISP_CTRL, OP_DISP_CTRL)) begin
        disp_d   = cap_data_q[2];
        cursor_d = cap_data_q[1];
        blink_d  = cap_data_q[0];
        go_cmd   = 1'b1;
      end else if (op_match(cap_data_q, MSK_ENTRY, OP_ENTRY)) begin
        id_d    = cap_data_q[1];
        shift_d = cap_data_q[0];
        go_cmd  = 1'b1;
      end else if (op_match(cap_data_q, MSK_HOME, OP_HOME)) begin
        ac_d   = '0;
        go_cmd = 1'b1;
      end else if (op_match(cap_data_q, MSK_CLEAR, OP_CLEAR)) begin
        state_d    = ST_CLR_FILL;
        fill_idx_d = '0;
        cnt_d      = CLEAR_LOAD;
      end
    end

    if (go_cmd) begin
      state_d = ST_CMD_WAIT;
      cnt_d   = CMD_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT_FILL;
      cnt_q      <= '0;
      fill_idx_q <= '0;
      e_s1_q     <= 1'b0;
      e_s2_q     <= 1'b0;
      e_prev_q   <= 1'b0;
      cap_rs_q   <= 1'b0;
      cap_rw_q   <= 1'b0;
      cap_data_q <= 8'h00;
      ac_q       <= '0;
      id_q       <= 1'b1;
      shift_q    <= 1'b0;
      dl_q       <= 1'b0;
      font_q     <= 1'b0;
      two_line_q <= 1'b0;
      disp_q     <= 1'b0;
      cursor_q   <= 1'b0;
      blink_q    <= 1'b0;
      cg_mode_q  <= 1'b0;
      viol_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_idx_q <= fill_idx_d;
      e_s1_q     <= e_s1_d;
      e_s2_q     <= e_s2_d;
      e_prev_q   <= e_prev_d;
      cap_rs_q   <= cap_rs_d;
      cap_rw_q   <= cap_rw_d;
      cap_data_q <= cap_data_d;
      ac_q       <= ac_d;
      id_q       <= id_d;
      shift_q    <= shift_d;
      dl_q       <= dl_d;
      font_q     <= font_d;
      two_line_q <= two_line_d;
      disp_q     <= disp_d;
      cursor_q   <= cursor_d;
      blink_q    <= blink_d;
      cg_mode_q  <= cg_mode_d;
      viol_q     <= viol_d;
    end
  end

  lcd_ddram u_ddram (
    .clk       (clk),
    .rst_n     (rst),
    .we        (ram_we),
    .waddr     (ram_waddr),
    .wdata     (ram_wdata),
    .raddr     (phys_ac),
    .rdata     (ram_rdata),
    .char_addr (char_addr),
    .char_out  (char_out)
  );

  assign busy      = ~is_idle;
  assign addr_ctr  = ac_q;
  assign disp_on   = disp_q;
  assign cursor_on = cursor_q;
  assign blink_on  = blink_q;
  assign two_line  = two_line_q;
  assign viol      = viol_q;
  assign LCD_DOE   = e_s2_q & cap_rw_q;
  assign LCD_DOUT  = LCD_DOE ? (cap_rs_q ? ram_rdata : {busy, ac_q}) : 8'h00;

endmodule
